// File: rtl/video_osd_pkg.sv
// Shared types and default colours for the on-screen-display overlay.
package video_osd_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam rgb_t BORDER_COLOR_DEF = 24'hFF0000;
    localparam rgb_t SQ_COLOR_DEF     = 24'h00FF00;
    localparam rgb_t RGB_IDLE         = 24'h000000;

endpackage

// File: rtl/video_osd_overlay_sprite.sv
// Bouncing-sprite position: steps once per frame event on each axis and
// reverses direction when it meets either screen edge.
module osd_sprite_mover
    import video_osd_pkg::*;
#(
    parameter int HDISP   = 800,
    parameter int VDISP   = 480,
    parameter int SQ_SIZE = 32,
    parameter int STEP    = 4
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    input  logic                       i_frame_evt,
    output logic [$clog2(HDISP)-1:0]   o_sq_x,
    output logic [$clog2(VDISP)-1:0]   o_sq_y
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);

    typedef logic [XW:0] xw_t;
    typedef logic [YW:0] yw_t;

    localparam xw_t X_MAX  = xw_t'(HDISP - SQ_SIZE);
    localparam yw_t Y_MAX  = yw_t'(VDISP - SQ_SIZE);
    localparam xw_t X_STEP = xw_t'(STEP);
    localparam yw_t Y_STEP = yw_t'(STEP);

    logic [XW-1:0] r_sq_x;
    logic [YW-1:0] r_sq_y;
    dir_t          r_dir_x;
    dir_t          r_dir_y;

    xw_t w_x_fwd;
    yw_t w_y_fwd;

    // One bit of headroom keeps the forward sum from wrapping before the compare.
    assign w_x_fwd = {1'b0, r_sq_x} + X_STEP;
    assign w_y_fwd = {1'b0, r_sq_y} + Y_STEP;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_sq_x  <= '0;
            r_dir_x <= DIR_POS;
        end else if (i_frame_evt) begin
            if (r_dir_x == DIR_POS) begin
                if (w_x_fwd >= X_MAX) begin
                    r_sq_x  <= X_MAX[XW-1:0];
                    r_dir_x <= DIR_NEG;
                end else begin
                    r_sq_x  <= w_x_fwd[XW-1:0];
                end
            end else begin
                if ({1'b0, r_sq_x} <= X_STEP) begin
                    r_sq_x  <= '0;
                    r_dir_x <= DIR_POS;
                end else begin
                    r_sq_x  <= r_sq_x - X_STEP[XW-1:0];
                end
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_sq_y  <= '0;
            r_dir_y <= DIR_POS;
        end else if (i_frame_evt) begin
            if (r_dir_y == DIR_POS) begin
                if (w_y_fwd >= Y_MAX) begin
                    r_sq_y  <= Y_MAX[YW-1:0];
                    r_dir_y <= DIR_NEG;
                end else begin
                    r_sq_y  <= w_y_fwd[YW-1:0];
                end
            end else begin
                if ({1'b0, r_sq_y} <= Y_STEP) begin
                    r_sq_y  <= '0;
                    r_dir_y <= DIR_POS;
                end else begin
                    r_sq_y  <= r_sq_y - Y_STEP[YW-1:0];
                end
            end
        end
    end

    assign o_sq_x = r_sq_x;
    assign o_sq_y = r_sq_y;

endmodule

// File: rtl/video_osd_overlay.sv
// Two-stage pixel pipeline that overlays a frame border and a bouncing
// sprite on the incoming video stream; sync/blank are delayed to match.
module video_osd_overlay
    import video_osd_pkg::*;
#(
    parameter int   HDISP        = 800,
    parameter int   VDISP        = 480,
    parameter int   SQ_SIZE      = 32,
    parameter int   STEP         = 4,
    parameter rgb_t BORDER_COLOR = BORDER_COLOR_DEF,
    parameter rgb_t SQ_COLOR     = SQ_COLOR_DEF
) (
    input  logic         pixel_clk,
    input  logic         pixel_rst,
    input  logic         osd_en,
    input  logic [23:0]  in_rgb,
    input  logic         in_hs,
    input  logic         in_vs,
    input  logic         in_blank,
    output logic [23:0]  out_rgb,
    output logic         out_hs,
    output logic         out_vs,
    output logic         out_blank,
    output logic [15:0]  frame_cnt
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);

    typedef logic [XW-1:0] x_t;
    typedef logic [YW-1:0] y_t;
    typedef logic [XW:0]   xw_t;
    typedef logic [YW:0]   yw_t;

    localparam x_t  X_LAST = x_t'(HDISP - 1);
    localparam y_t  Y_LAST = y_t'(VDISP - 1);
    localparam xw_t X_SQ   = xw_t'(SQ_SIZE);
    localparam yw_t Y_SQ   = yw_t'(SQ_SIZE);

    x_t    r_x_cnt;
    y_t    r_y_cnt;
    x_t    r_x_s1;
    y_t    r_y_s1;
    rgb_t  r_rgb_s1;
    logic  r_hs_s1;
    logic  r_vs_s1;
    logic  r_blank_s1;
    logic  r_en_frame;
    logic [15:0] r_frame_cnt;

    rgb_t  r_rgb_s2;
    logic  r_hs_s2;
    logic  r_vs_s2;
    logic  r_blank_s2;

    logic  w_frame_evt;
    logic  w_line_end;
    x_t    w_sq_x;
    y_t    w_sq_y;
    logic  w_border;
    logic  w_in_x;
    logic  w_in_y;
    rgb_t  w_rgb_mux;

    // Stage-1 copies of vs/blank double as the edge-detect history.
    assign w_frame_evt = r_vs_s1 & ~in_vs;
    assign w_line_end  = r_blank_s1 & ~in_blank;

    osd_sprite_mover #(
        .HDISP   (HDISP),
        .VDISP   (VDISP),
        .SQ_SIZE (SQ_SIZE),
        .STEP    (STEP)
    ) u_mover (
        .pixel_clk   (pixel_clk),
        .pixel_rst   (pixel_rst),
        .i_frame_evt (w_frame_evt),
        .o_sq_x      (w_sq_x),
        .o_sq_y      (w_sq_y)
    );

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_x_s1      <= '0;
            r_y_s1      <= '0;
            r_rgb_s1    <= RGB_IDLE;
            r_hs_s1     <= 1'b1;
            r_vs_s1     <= 1'b1;
            r_blank_s1  <= 1'b0;
            r_en_frame  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // Counters hold the coordinate of the pixel currently at the input.
            if (!in_blank) begin
                r_x_cnt <= '0;
            end else if (r_x_cnt != X_LAST) begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end

            if (!in_vs) begin
                r_y_cnt <= '0;
            end else if (w_line_end && (r_y_cnt != Y_LAST)) begin
                r_y_cnt <= r_y_cnt + 1'b1;
            end

            r_x_s1     <= r_x_cnt;
            r_y_s1     <= r_y_cnt;
            r_rgb_s1   <= in_rgb;
            r_hs_s1    <= in_hs;
            r_vs_s1    <= in_vs;
            r_blank_s1 <= in_blank;

            if (w_frame_evt) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_en_frame  <= osd_en;
            end
        end
    end

    assign w_border = (r_x_s1 == '0) || (r_x_s1 == X_LAST) ||
                      (r_y_s1 == '0) || (r_y_s1 == Y_LAST);

    assign w_in_x = ({1'b0, r_x_s1} >= {1'b0, w_sq_x}) &&
                    ({1'b0, r_x_s1} <  ({1'b0, w_sq_x} + X_SQ));
    assign w_in_y = ({1'b0, r_y_s1} >= {1'b0, w_sq_y}) &&
                    ({1'b0, r_y_s1} <  ({1'b0, w_sq_y} + Y_SQ));

    always_comb begin
        w_rgb_mux = r_rgb_s1;
        if (r_en_frame && r_blank_s1) begin
            if (w_border) begin
                w_rgb_mux = BORDER_COLOR;
            end else if (w_in_x && w_in_y) begin
                w_rgb_mux = SQ_COLOR;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_rgb_s2   <= RGB_IDLE;
            r_hs_s2    <= 1'b1;
            r_vs_s2    <= 1'b1;
            r_blank_s2 <= 1'b0;
        end else begin
            r_rgb_s2   <= w_rgb_mux;
            r_hs_s2    <= r_hs_s1;
            r_vs_s2    <= r_vs_s1;
            r_blank_s2 <= r_blank_s1;
        end
    end

    assign out_rgb   = r_rgb_s2;
    assign out_hs    = r_hs_s2;
    assign out_vs    = r_vs_s2;
    assign out_blank = r_blank_s2;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_video_osd_overlay.sv
// Directed bench for video_osd_overlay on a reduced 16x12 raster so that
// many frames, bounces, a mid-line reset and a counter wrap fit in a short run.
module tb_video_osd_overlay;
    import video_osd_pkg::*;

    localparam int HD = 16;
    localparam int VD = 12;
    localparam int SQ = 4;
    localparam int ST = 3;
    localparam logic [23:0] RED = 24'hFF0000;
    localparam logic [23:0] GRN = 24'h00FF00;
    localparam int P_IN = 0;
    localparam int P_BD = 1;
    localparam int P_SQ = 2;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b1;
    logic        osd_en    = 1'b0;
    logic [23:0] in_rgb;
    logic        in_hs;
    logic        in_vs;
    logic        in_blank;
    logic [23:0] out_rgb;
    logic        out_hs;
    logic        out_vs;
    logic        out_blank;
    logic [15:0] frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic        chk_rgb = 1'b0;
    logic [23:0] ramp    = 24'h123400;
    logic [23:0] h1_rgb, h2_rgb;
    logic [2:0]  h1_ctl, h2_ctl;
    int          h1_x, h1_y, h2_x, h2_y;
    logic [23:0] cap_out [VD][HD];
    logic [23:0] cap_in  [VD][HD];

    video_osd_overlay #(
        .HDISP        (HD),
        .VDISP        (VD),
        .SQ_SIZE      (SQ),
        .STEP         (ST),
        .BORDER_COLOR (RED),
        .SQ_COLOR     (GRN)
    ) dut (
        .pixel_clk (pixel_clk),
        .pixel_rst (pixel_rst),
        .osd_en    (osd_en),
        .in_rgb    (in_rgb),
        .in_hs     (in_hs),
        .in_vs     (in_vs),
        .in_blank  (in_blank),
        .out_rgb   (out_rgb),
        .out_hs    (out_hs),
        .out_vs    (out_vs),
        .out_blank (out_blank),
        .frame_cnt (frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        in_rgb   = 24'h0;
        in_hs    = 1'b1;
        in_vs    = 1'b1;
        in_blank = 1'b0;
        h1_rgb = 24'h0;  h2_rgb = 24'h0;
        h1_ctl = 3'b110; h2_ctl = 3'b110;
        h1_x = 0; h1_y = 0; h2_x = 0; h2_y = 0;
    endtask

    // One pixel: check the output against the input applied two cycles ago, then drive.
    task automatic cyc(input logic hs, input logic vs, input logic bl, input int x, input int y);
        @(negedge pixel_clk);
        chk("ctl_delay", {21'b0, out_hs, out_vs, out_blank}, {21'b0, h2_ctl});
        if (chk_rgb) chk("rgb_passthru", out_rgb, h2_rgb);
        if (h2_ctl[0]) begin
            cap_out[h2_y][h2_x] = out_rgb;
            cap_in[h2_y][h2_x]  = h2_rgb;
        end
        h2_rgb = h1_rgb; h2_ctl = h1_ctl; h2_x = h1_x; h2_y = h1_y;
        in_hs = hs; in_vs = vs; in_blank = bl; in_rgb = ramp;
        h1_rgb = ramp; h1_ctl = {hs, vs, bl}; h1_x = x; h1_y = y;
        ramp = ramp + 24'd1;
    endtask

    task automatic do_line(input logic vs, input logic act, input int y);
        for (int i = 0; i < HD; i++) cyc(1'b1, vs, act, i, y);
        cyc(1'b1, vs, 1'b0, 0, 0);
        cyc(1'b0, vs, 1'b0, 0, 0);
        cyc(1'b0, vs, 1'b0, 0, 0);
        cyc(1'b1, vs, 1'b0, 0, 0);
    endtask

    task automatic do_frame(input int tog_line, input logic tog_val);
        do_line(1'b0, 1'b0, 0);
        do_line(1'b0, 1'b0, 0);
        do_line(1'b1, 1'b0, 0);
        for (int y = 0; y < VD; y++) begin
            if (y == tog_line) osd_en = tog_val;
            do_line(1'b1, 1'b1, y);
        end
        do_line(1'b1, 1'b0, 0);
    endtask

    task automatic probe(input string tag, input int x, input int y, input int kind);
        logic [23:0] e;
        e = (kind == P_BD) ? RED : (kind == P_SQ) ? GRN : cap_in[y][x];
        chk($sformatf("%s(%0d,%0d)", tag, x, y), cap_out[y][x], e);
    endtask

    initial begin
        in_rgb = 24'hAAAAAA; in_hs = 1'b0; in_vs = 1'b0; in_blank = 1'b1; osd_en = 1'b1;
        repeat (3) @(negedge pixel_clk);
        chk("rst_rgb",   out_rgb, 24'h0);
        chk("rst_hs",    {23'b0, out_hs}, 24'h1);
        chk("rst_vs",    {23'b0, out_vs}, 24'h1);
        chk("rst_blank", {23'b0, out_blank}, 24'h0);
        chk("rst_fcnt",  {8'b0, frame_cnt}, 24'h0);

        osd_en = 1'b0;
        set_idle();
        pixel_rst = 1'b0;
        chk_rgb = 1'b1;
        do_line(1'b1, 1'b0, 0);

        // Frame 1: overlay disabled, pure 2-cycle delay.
        do_frame(-1, 1'b0);
        chk("fcnt_f1", {8'b0, frame_cnt}, 24'd1);

        // Frame 2: sprite at (6,6).
        osd_en = 1'b1; chk_rgb = 1'b0;
        do_frame(-1, 1'b0);
        chk("fcnt_f2", {8'b0, frame_cnt}, 24'd2);
        probe("f2", 0, 0, P_BD);   probe("f2", 15, 0, P_BD);
        probe("f2", 0, 11, P_BD);  probe("f2", 15, 11, P_BD);
        probe("f2", 5, 0, P_BD);   probe("f2", 0, 5, P_BD);
        probe("f2", 6, 6, P_SQ);   probe("f2", 9, 9, P_SQ);
        probe("f2", 10, 10, P_IN); probe("f2", 5, 6, P_IN);
        probe("f2", 6, 5, P_IN);   probe("f2", 10, 9, P_IN);
        probe("f2", 9, 10, P_IN);

        // Frame 3: (9,8), y clamped to 8 and turns.
        do_frame(-1, 1'b0);
        probe("f3", 9, 8, P_SQ);   probe("f3", 12, 10, P_SQ);
        probe("f3", 12, 11, P_BD); probe("f3", 13, 10, P_IN);
        probe("f3", 8, 9, P_IN);   probe("f3", 9, 7, P_IN);

        // Frame 4: (12,5), x lands exactly on its limit and turns.
        do_frame(-1, 1'b0);
        probe("f4", 12, 5, P_SQ);  probe("f4", 14, 8, P_SQ);
        probe("f4", 15, 6, P_BD);  probe("f4", 11, 6, P_IN);
        probe("f4", 13, 9, P_IN);  probe("f4", 13, 4, P_IN);

        // Frame 5: (9,2).
        do_frame(-1, 1'b0);
        probe("f5", 9, 2, P_SQ);   probe("f5", 12, 5, P_SQ);
        probe("f5", 9, 1, P_IN);   probe("f5", 13, 3, P_IN);

        // Frame 6: (6,0), y clamped to 0; border wins over sprite.
        do_frame(-1, 1'b0);
        probe("f6", 6, 0, P_BD);   probe("f6", 7, 1, P_SQ);
        probe("f6", 9, 3, P_SQ);   probe("f6", 7, 4, P_IN);
        probe("f6", 5, 2, P_IN);

        // Frame 7: (3,3).
        do_frame(-1, 1'b0);
        probe("f7", 3, 3, P_SQ);   probe("f7", 6, 6, P_SQ);
        probe("f7", 2, 3, P_IN);   probe("f7", 7, 3, P_IN);

        // Frame 8: (0,6), x reaches 0 with sq_x == STEP.
        do_frame(-1, 1'b0);
        probe("f8", 0, 6, P_BD);   probe("f8", 1, 7, P_SQ);
        probe("f8", 3, 9, P_SQ);   probe("f8", 4, 7, P_IN);
        probe("f8", 1, 10, P_IN);  probe("f8", 1, 5, P_IN);
        chk("fcnt_f8", {8'b0, frame_cnt}, 24'd8);

        // Frame 9: (3,8); osd_en dropped on line 2 must not affect this frame.
        do_frame(2, 1'b0);
        probe("f9", 3, 8, P_SQ);   probe("f9", 6, 10, P_SQ);
        probe("f9", 6, 11, P_BD);  probe("f9", 0, 11, P_BD);
        probe("f9", 0, 3, P_BD);   probe("f9", 2, 8, P_IN);
        probe("f9", 7, 9, P_IN);

        // Frame 10: overlay off from the VS edge on.
        chk_rgb = 1'b1;
        do_frame(-1, 1'b0);
        probe("f10", 0, 0, P_IN);  probe("f10", 6, 5, P_IN);
        probe("f10", 15, 11, P_IN);
        chk("fcnt_f10", {8'b0, frame_cnt}, 24'd10);

        // Frame 11, cut short by a reset in the middle of line 2.
        osd_en = 1'b1; chk_rgb = 1'b0;
        do_line(1'b0, 1'b0, 0);
        do_line(1'b0, 1'b0, 0);
        do_line(1'b1, 1'b0, 0);
        do_line(1'b1, 1'b1, 0);
        do_line(1'b1, 1'b1, 1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, i, 2);
        probe("f11", 0, 1, P_BD);
        chk("fcnt_f11", {8'b0, frame_cnt}, 24'd11);
        #2 pixel_rst = 1'b1;
        #1;
        chk("mid_rst_rgb",   out_rgb, 24'h0);
        chk("mid_rst_hs",    {23'b0, out_hs}, 24'h1);
        chk("mid_rst_vs",    {23'b0, out_vs}, 24'h1);
        chk("mid_rst_blank", {23'b0, out_blank}, 24'h0);
        chk("mid_rst_fcnt",  {8'b0, frame_cnt}, 24'h0);
        repeat (2) @(negedge pixel_clk);
        set_idle();
        pixel_rst = 1'b0;

        // Active lines before any VS edge: overlay stays off despite osd_en=1.
        chk_rgb = 1'b1;
        do_line(1'b1, 1'b0, 0);
        do_line(1'b1, 1'b1, 0);
        do_line(1'b1, 1'b1, 1);
        do_line(1'b1, 1'b0, 0);
        probe("post_rst", 0, 0, P_IN);
        probe("post_rst", 0, 1, P_IN);

        // First frame after reset: sprite restarted, one update to (3,3).
        chk_rgb = 1'b0;
        do_frame(-1, 1'b0);
        chk("fcnt_f12", {8'b0, frame_cnt}, 24'd1);
        probe("f12", 3, 3, P_SQ);  probe("f12", 6, 6, P_SQ);
        probe("f12", 0, 0, P_BD);  probe("f12", 2, 2, P_IN);
        probe("f12", 7, 7, P_IN);

        // Counter wrap.
        force dut.r_frame_cnt = 16'hFFFF;
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        release dut.r_frame_cnt;
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        do_frame(-1, 1'b0);
        chk("fcnt_wrap", {8'b0, frame_cnt}, 24'h0);
        do_frame(-1, 1'b0);
        chk("fcnt_after_wrap", {8'b0, frame_cnt}, 24'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
